// File: rtl/jkcnt_pkg.sv
// Shared JK cell codes, FSM state encoding and helpers for the JK counter sequencer.
package jkcnt_pkg;

    // {J,K} pair driven into one cell
    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_code_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // JK pair that forces a cell to a given bit value on the next edge
    function automatic jk_code_e jk_load(input logic b);
        return b ? JK_SET : JK_RESET;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-low clear.
module jk_cell
    import jkcnt_pkg::*;
(
    input  logic     clk,
    input  logic     clrn,
    input  jk_code_e jk,
    output logic     q
);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            q <= 1'b0;
        end else begin
            case (jk)
                JK_HOLD:   q <= q;
                JK_RESET:  q <= 1'b0;
                JK_SET:    q <= 1'b1;
                JK_TOGGLE: q <= ~q;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_counter_ctrl.sv
// Run/stop sequencer that decodes per-bit J/K pairs for a JK-cell counter array.
// Define JKCNT_DOWN_EN to enable down counting selected by the up input.
module jk_counter_ctrl
    import jkcnt_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             auto_reload,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc
);

    state_e   state;
    state_e   state_next;
    logic     tc_next;
    jk_code_e jk [WIDTH];

`ifndef JKCNT_DOWN_EN
    logic unused_up;
    assign unused_up = up;
`endif

    // State, busy and terminal-count registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            tc    <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == ST_RUN);
            tc    <= tc_next;
        end
    end

    // Next state and J/K decode; priority load > stop > terminal/step > start
    always_comb begin
        logic chain;
        logic terminal;
        state_next = state;
        tc_next    = 1'b0;
        chain      = 1'b1;
        terminal   = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            jk[i] = JK_HOLD;
        end

        if (load) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                jk[i] = jk_load(load_val[i]);
            end
        end else if (state == ST_RUN) begin
            if (stop) begin
                state_next = ST_IDLE;
            end else begin
`ifdef JKCNT_DOWN_EN
                if (!up) begin
                    if (q == '0) begin
                        terminal = 1'b1;
                        for (int i = 0; i < int'(WIDTH); i++) begin
                            jk[i] = jk_load(limit[i]);
                        end
                    end else begin
                        // bit i toggles when every lower bit is 0 (borrow chain)
                        for (int i = 0; i < int'(WIDTH); i++) begin
                            jk[i] = chain ? JK_TOGGLE : JK_HOLD;
                            chain = chain & ~q[i];
                        end
                    end
                end else
`endif
                begin
                    if (q == limit) begin
                        terminal = 1'b1;
                        for (int i = 0; i < int'(WIDTH); i++) begin
                            jk[i] = JK_RESET;
                        end
                    end else begin
                        // bit i toggles when every lower bit is 1 (carry chain)
                        for (int i = 0; i < int'(WIDTH); i++) begin
                            jk[i] = chain ? JK_TOGGLE : JK_HOLD;
                            chain = chain & q[i];
                        end
                    end
                end
                if (terminal) begin
                    tc_next = 1'b1;
                    if (!auto_reload) begin
                        state_next = ST_IDLE;
                    end
                end
            end
        end else if (start && !stop) begin
            state_next = ST_RUN;
        end
    end

    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_cell
        jk_cell u_cell (
            .clk  (clk),
            .clrn (clrn),
            .jk   (jk[g]),
            .q    (q[g])
        );
    end

endmodule
